// File: rtl/eth_mac_tx_arbiter_pkg.sv
// Shared types and helpers for the Ethernet MAC TX arbiter.
//   arb_state_t : arbiter FSM states (idle, frame transfer, inter-frame gap)
//   MAX_SRC     : largest supported number of sources
//   rr_pick     : round-robin pick, returns one-hot winner over MAX_SRC bits
package eth_tx_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_XFER, ARB_GAP} arb_state_t;

  localparam int MAX_SRC   = 8;
  localparam int PTR_MAX_W = 3;

  // Scan starts one past the pointer and wraps at n, so the previous winner
  // is considered last. Bits of req at or above n must be zero.
  function automatic logic [MAX_SRC-1:0] rr_pick(input logic [MAX_SRC-1:0]   req,
                                                 input logic [PTR_MAX_W-1:0] ptr,
                                                 input int                   n);
    logic [MAX_SRC-1:0]   win;
    logic [PTR_MAX_W-1:0] idx;
    win = '0;
    for (int k = 1; k <= MAX_SRC; k++) begin
      idx = PTR_MAX_W'((int'(ptr) + k) % n);
      if (k <= n && win == '0 && req[idx]) win[idx] = 1'b1;
    end
    return win;
  endfunction

endpackage

// File: rtl/eth_mac_tx_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   i_req    : request vector, one bit per source
//   i_ptr    : index of the most recent winner
//   o_winner : one-hot winner (all zero when no request)
//   o_valid  : at least one source is requesting
module rr_arbiter
  import eth_tx_arb_pkg::*;
#(
  parameter int NUM_SRC = 2,
  localparam int PTR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_SRC-1:0] o_winner,
  output logic               o_valid
);

  logic [MAX_SRC-1:0]   w_req_pad;
  logic [PTR_MAX_W-1:0] w_ptr_pad;
  logic [MAX_SRC-1:0]   w_win_full;

  assign w_req_pad  = MAX_SRC'(i_req);
  assign w_ptr_pad  = PTR_MAX_W'(i_ptr);
  assign w_win_full = rr_pick(w_req_pad, w_ptr_pad, NUM_SRC);
  assign o_winner   = w_win_full[NUM_SRC-1:0];
  assign o_valid    = |w_win_full;

endmodule

// File: rtl/eth_mac_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the Ethernet MAC TX stream.
// A granted source owns the MAC until its tlast beat is accepted; a fixed
// idle gap follows every frame before the next arbitration.
//   clk_125, reset_n      : clock, synchronous active-low reset
//   s_axis_tdata/tvalid/tlast/trdy : per-source AXI-stream inputs
//   m_tx_axis_tdata/tvalid/tlast/trdy : muxed stream toward the MAC
//   grant                 : registered one-hot grant (zero outside transfer)
//   busy                  : high during transfer and gap
module eth_mac_tx_arbiter
  import eth_tx_arb_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 12
) (
  input  logic                          clk_125,
  input  logic                          reset_n,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  output logic [NUM_SRC-1:0]            s_axis_trdy,
  output logic [DATA_WIDTH-1:0]         m_tx_axis_tdata,
  output logic                          m_tx_axis_tvalid,
  output logic                          m_tx_axis_tlast,
  input  logic                          m_tx_axis_trdy,
  output logic [NUM_SRC-1:0]            grant,
  output logic                          busy
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  arb_state_t         r_state;
  logic [NUM_SRC-1:0] r_grant;
  logic [PTR_W-1:0]   r_ptr;
  logic               r_busy;

  logic [NUM_SRC-1:0]    w_win;
  logic                  w_win_vld;
  logic [PTR_W-1:0]      w_gidx;
  logic [DATA_WIDTH-1:0] w_tdata;
  logic                  w_last_acc;
  logic                  w_gap_done;

  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
    .i_req    (s_axis_tvalid),
    .i_ptr    (r_ptr),
    .o_winner (w_win),
    .o_valid  (w_win_vld)
  );

  // Grant is zero outside transfer, so an AND-OR mux also yields the
  // all-zero idle outputs without a separate state qualifier.
  always_comb begin
    w_tdata = '0;
    w_gidx  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_tdata = w_tdata | (s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{r_grant[i]}});
      if (r_grant[i]) w_gidx = PTR_W'(i);
    end
  end

  assign m_tx_axis_tdata  = w_tdata;
  assign m_tx_axis_tvalid = |(r_grant & s_axis_tvalid);
  assign m_tx_axis_tlast  = |(r_grant & s_axis_tlast);
  assign s_axis_trdy      = r_grant & {NUM_SRC{m_tx_axis_trdy}};
  assign grant            = r_grant;
  assign busy             = r_busy;

  assign w_last_acc = (r_state == ARB_XFER) && m_tx_axis_tvalid && m_tx_axis_trdy && m_tx_axis_tlast;

  generate
    if (GAP_CYCLES > 0) begin : g_gap
      localparam int CNT_W = $clog2(GAP_CYCLES + 1);
      logic [CNT_W-1:0] r_gap_cnt;

      // Loaded with GAP_CYCLES-1 so the state spends exactly GAP_CYCLES cycles in GAP.
      always_ff @(posedge clk_125) begin
        if (!reset_n) begin
          r_gap_cnt <= '0;
        end else if (w_last_acc) begin
          r_gap_cnt <= CNT_W'(GAP_CYCLES - 1);
        end else if (r_state == ARB_GAP && r_gap_cnt != '0) begin
          r_gap_cnt <= r_gap_cnt - CNT_W'(1);
        end
      end

      assign w_gap_done = (r_gap_cnt == '0);
    end else begin : g_no_gap
      assign w_gap_done = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk_125) begin
    if (!reset_n) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_ptr   <= PTR_W'(NUM_SRC - 1);
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_win_vld) begin
            r_grant <= w_win;
            r_busy  <= 1'b1;
            r_state <= ARB_XFER;
          end
        end
        ARB_XFER: begin
          // Grant is held through source tvalid bubbles; only tlast releases it.
          if (w_last_acc) begin
            r_ptr   <= w_gidx;
            r_grant <= '0;
            if (GAP_CYCLES == 0) begin
              r_busy  <= 1'b0;
              r_state <= ARB_IDLE;
            end else begin
              r_state <= ARB_GAP;
            end
          end
        end
        ARB_GAP: begin
          if (w_gap_done) begin
            r_busy  <= 1'b0;
            r_state <= ARB_IDLE;
          end
        end
        default: begin
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_mac_tx_arbiter.sv
// Scoreboard bench for eth_mac_tx_arbiter: a GAP_CYCLES=12 instance (dut)
// and a GAP_CYCLES=0 instance (zdut) share clock and reset.
module tb_eth_mac_tx_arbiter;

  localparam int GAP = 12;

  typedef struct {
    string      name;
    int         kind;   // 0 dut state, 1 zdut state, 2 timeout, 3 drain
    logic [1:0] grant;
    logic       busy;
    logic       mtv;
  } snap_t;

  logic clk_125 = 1'b0;
  always #4 clk_125 = ~clk_125;

  logic        reset_n;
  logic [15:0] s_tdata;
  logic [1:0]  s_tvalid, s_tlast, s_trdy;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast, m_trdy;
  logic [1:0]  grant;
  logic        busy;

  logic [15:0] z_tdata;
  logic [1:0]  z_tvalid, z_tlast, z_trdy;
  logic [7:0]  z_m_tdata;
  logic        z_m_tvalid, z_m_tlast, z_m_trdy;
  logic [1:0]  z_grant;
  logic        z_busy;

  eth_mac_tx_arbiter #(.NUM_SRC(2), .DATA_WIDTH(8), .GAP_CYCLES(GAP)) dut (
    .clk_125(clk_125), .reset_n(reset_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_trdy(s_trdy),
    .m_tx_axis_tdata(m_tdata), .m_tx_axis_tvalid(m_tvalid), .m_tx_axis_tlast(m_tlast),
    .m_tx_axis_trdy(m_trdy), .grant(grant), .busy(busy)
  );

  eth_mac_tx_arbiter #(.NUM_SRC(2), .DATA_WIDTH(8), .GAP_CYCLES(0)) zdut (
    .clk_125(clk_125), .reset_n(reset_n),
    .s_axis_tdata(z_tdata), .s_axis_tvalid(z_tvalid), .s_axis_tlast(z_tlast), .s_axis_trdy(z_trdy),
    .m_tx_axis_tdata(z_m_tdata), .m_tx_axis_tvalid(z_m_tvalid), .m_tx_axis_tlast(z_m_tlast),
    .m_tx_axis_trdy(z_m_trdy), .grant(z_grant), .busy(z_busy)
  );

  // Source beat queues {last, data}; expected MAC beats {grant, last, data}.
  logic [8:0]  q0[$], q1[$], zq0[$], zq1[$];
  logic [10:0] exp_q[$], zexp_q[$];
  snap_t       snap_q[$];

  int   hold0, hold_at;
  logic tog, force_v, mon_en;
  int   errors, checks, gap_run;

  // ---------------- monitor / checker ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk_125) begin
    snap_t       s;
    logic [10:0] e;
    if (mon_en) begin
      if (m_tvalid === 1'b1 && m_trdy === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat_unexpected: got 0x%0h expected none", {grant, m_tlast, m_tdata});
        end else begin
          e = exp_q.pop_front();
          chk("beat", 32'({grant, m_tlast, m_tdata}), 32'(e));
        end
      end
      if (z_m_tvalid === 1'b1 && z_m_trdy === 1'b1) begin
        if (zexp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL zbeat_unexpected: got 0x%0h expected none", {z_grant, z_m_tlast, z_m_tdata});
        end else begin
          e = zexp_q.pop_front();
          chk("zbeat", 32'({z_grant, z_m_tlast, z_m_tdata}), 32'(e));
        end
      end
      chk("trdy_mirror", 32'(s_trdy), 32'(grant & {2{m_trdy}}));
      chk("ztrdy_mirror", 32'(z_trdy), 32'(z_grant & {2{z_m_trdy}}));
      if (busy === 1'b1 && grant === 2'b00) begin
        gap_run++;
      end else begin
        if (gap_run > 0) chk("gap_len", 32'(gap_run), 32'(GAP));
        gap_run = 0;
      end
      while (snap_q.size() > 0) begin
        s = snap_q.pop_front();
        case (s.kind)
          0: begin
            chk(s.name, 32'({grant, busy, m_tvalid}), 32'({s.grant, s.busy, s.mtv}));
            if (s.grant == 2'b00) chk({s.name, "_quiet"}, 32'({m_tlast, m_tdata}), 32'd0);
          end
          1: begin
            chk(s.name, 32'({z_grant, z_busy, z_m_tvalid}), 32'({s.grant, s.busy, s.mtv}));
            if (s.grant == 2'b00) chk({s.name, "_quiet"}, 32'({z_m_tlast, z_m_tdata}), 32'd0);
          end
          2: begin
            checks++; errors++;
            $display("FAIL %s: got timeout expected completion", s.name);
          end
          default: begin
            chk("drain", 32'(exp_q.size()), 32'd0);
            chk("zdrain", 32'(zexp_q.size()), 32'd0);
          end
        endcase
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive();
    s_tvalid = 2'b00; s_tlast = 2'b00; s_tdata = '0;
    z_tvalid = 2'b00; z_tlast = 2'b00; z_tdata = '0;
    if (q0.size() > 0 && hold0 == 0) begin s_tvalid[0] = 1'b1; {s_tlast[0], s_tdata[7:0]} = q0[0]; end
    if (q1.size() > 0) begin s_tvalid[1] = 1'b1; {s_tlast[1], s_tdata[15:8]} = q1[0]; end
    if (zq0.size() > 0) begin z_tvalid[0] = 1'b1; {z_tlast[0], z_tdata[7:0]} = zq0[0]; end
    if (zq1.size() > 0) begin z_tvalid[1] = 1'b1; {z_tlast[1], z_tdata[15:8]} = zq1[0]; end
    if (force_v) begin s_tvalid = 2'b11; z_tvalid = 2'b11; end
  endtask

  task automatic tick();
    logic f0, f1, g0, g1;
    @(negedge clk_125);
    f0 = s_tvalid[0] && s_trdy[0];
    f1 = s_tvalid[1] && s_trdy[1];
    g0 = z_tvalid[0] && z_trdy[0];
    g1 = z_tvalid[1] && z_trdy[1];
    @(posedge clk_125);
    #1;
    if (f0) void'(q0.pop_front());
    if (f1) void'(q1.pop_front());
    if (g0) void'(zq0.pop_front());
    if (g1) void'(zq1.pop_front());
    if (hold0 > 0) hold0--;
    if (hold_at >= 0 && q0.size() == hold_at) begin hold0 = 5; hold_at = -1; end
    if (tog) m_trdy = ~m_trdy;
    drive();
  endtask

  task automatic snap(string n, int k, logic [1:0] g, logic b, logic v);
    snap_q.push_back('{name: n, kind: k, grant: g, busy: b, mtv: v});
  endtask

  task automatic push_frame(int src, int len, logic [7:0] base, int exp_len);
    logic [7:0] d;
    logic       l;
    for (int k = 0; k < len; k++) begin
      d = 8'(base + 8'(k));
      l = (k == len - 1);
      if (src == 0) q0.push_back({l, d}); else q1.push_back({l, d});
      if (k < exp_len) exp_q.push_back({(src == 1) ? 2'b10 : 2'b01, l, d});
    end
  endtask

  function automatic bit pending();
    return (q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0 ||
            zq0.size() != 0 || zq1.size() != 0 || zexp_q.size() != 0 ||
            busy !== 1'b0 || z_busy !== 1'b0);
  endfunction

  task automatic run_until(string n, int lim);
    int c;
    c = 0;
    while (pending()) begin
      if (c >= lim) begin snap(n, 2, 2'b00, 1'b0, 1'b0); break; end
      tick();
      c++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int c;
    reset_n = 1'b0; force_v = 1'b1; m_trdy = 1'b0; z_m_trdy = 1'b1; tog = 1'b0;
    hold0 = 0; hold_at = -1; mon_en = 1'b0; errors = 0; checks = 0; gap_run = 0;
    drive();
    tick();
    mon_en = 1'b1;

    // Reset held with both sources valid
    tick(); snap("rst_state", 0, 2'b00, 1'b0, 1'b0); snap("zrst_state", 1, 2'b00, 1'b0, 1'b0);
    tick(); snap("rst_state2", 0, 2'b00, 1'b0, 1'b0);
    force_v = 1'b0; m_trdy = 1'b1; reset_n = 1'b1;

    // Single 64-byte frame from source 0
    push_frame(0, 64, 8'h00, 64);
    drive();
    snap("grant_lat0", 0, 2'b00, 1'b0, 1'b0);
    tick(); snap("grant_lat1", 0, 2'b01, 1'b1, 1'b1);
    c = 0;
    while (q0.size() != 0 && c < 200) begin tick(); c++; end
    if (q0.size() != 0) snap("t2_frame", 2, 2'b00, 1'b0, 1'b0);
    snap("gap_state", 0, 2'b00, 1'b1, 1'b0);
    run_until("t2_drain", 300);

    // Both sources, two 10-byte frames each, from a fresh pointer
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    push_frame(0, 10, 8'h10, 10);
    push_frame(1, 10, 8'h80, 10);
    push_frame(0, 10, 8'h20, 10);
    push_frame(1, 10, 8'h90, 10);
    drive();
    run_until("t3_drain", 400);

    // Backpressure, a 5-cycle tvalid bubble, and a pending single-beat on source 1
    tog = 1'b1; hold_at = 10;
    push_frame(0, 20, 8'h40, 20);
    push_frame(1, 1, 8'hC0, 1);
    drive();
    c = 0;
    while (hold0 == 0 && c < 200) begin tick(); c++; end
    if (hold0 == 0) snap("t4_hold", 2, 2'b00, 1'b0, 1'b0);
    repeat (5) begin snap("hold_grant", 0, 2'b01, 1'b1, 1'b0); tick(); end
    c = 0;
    while (q0.size() != 0 && c < 200) begin tick(); c++; end
    tog = 1'b0; m_trdy = 1'b1;
    run_until("t4_drain", 400);

    // Zero-gap instance: single-beat from source 1, then source 0 in the IDLE cycle
    zq1.push_back({1'b1, 8'hA5}); zexp_q.push_back({2'b10, 1'b1, 8'hA5});
    drive();
    snap("z_idle0", 1, 2'b00, 1'b0, 1'b0);
    tick(); snap("z_xfer1", 1, 2'b10, 1'b1, 1'b1);
    tick();
    zq0.push_back({1'b1, 8'h5A}); zexp_q.push_back({2'b01, 1'b1, 8'h5A});
    drive();
    snap("z_idle_mid", 1, 2'b00, 1'b0, 1'b0);
    tick(); snap("z_xfer0", 1, 2'b01, 1'b1, 1'b1);
    tick(); snap("z_idle_end", 1, 2'b00, 1'b0, 1'b0);

    // Reset while byte 7 of a 30-byte frame is on the bus
    push_frame(0, 30, 8'h60, 8);
    drive();
    c = 0;
    while (q0.size() > 23 && c < 200) begin tick(); c++; end
    reset_n = 1'b0;
    tick();
    snap("rst_mid", 0, 2'b00, 1'b0, 1'b0);
    q0.delete();
    push_frame(0, 2, 8'hD0, 2);
    push_frame(1, 2, 8'hE0, 2);
    reset_n = 1'b1;
    drive();
    tick(); snap("rel_grant0", 0, 2'b01, 1'b1, 1'b1);
    run_until("t6_drain", 300);
    snap("drain", 3, 2'b00, 1'b0, 1'b0);
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
